bus_protocol_checker: RTL and testbench
=======================================

# bus_protocol_checker

Synthesizable, parametrised run-time checker for the dValid/dAck/data transfer bus: tracks each transfer with a state machine and beat counter, and flags protocol violations in hardware instead of in simulation-only assertions. Sits passively beside any master/target pair on the bus; it drives nothing on the bus. It supports configurable data width and valid-window length, sticky per-class error flags, a first-error code and a clean-transfer counter, for use in emulation and silicon debug.

## Interface
- `DATA_W`, 8: bus data width.
- `MIN_VALID`, 2: minimum beats dValid is high per transfer (≥1).
- `MAX_VALID`, 4: maximum beats dValid is high per transfer (≥`MIN_VALID`).
- `CNT_W`, 16: width of all counters.

- `clk`  in  1  clock; all sampling on posedge.
- `reset`  in  1  asynchronous, active-low reset.
- `dValid`  in  1  monitored bus valid.
- `dAck`  in  1  monitored bus acknowledge.
- `data`  in  `DATA_W`  monitored bus data.
- `err_clr`  in  1  synchronous clear of `err_flags`/`err_code`.
- `busy`  out  1  transfer in progress (state ≠ IDLE).
- `err_pulse`  out  1  one-cycle pulse, any new error this edge.
- `err_flags`  out  6  sticky error bits: [0] SPURIOUS_ACK, [1] ACK_EARLY, [2] LEN_LONG, [3] NO_ACK, [4] NO_DROP, [5] DATA_UNSTABLE.
- `err_code`  out  3  index+1 of first error since clear; 0 = none.
- `xfer_cnt`  out  `CNT_W`  count of error-free completed transfers, saturating.
- `err_cnt`  out  `CNT_W`  count of error events (see Configuration).

## Operation
- States: IDLE, ACTIVE, ACKED, RECOVER. Beat counter `b`, width clog2(`MAX_VALID`+2); `cap` holds data; `dirty` marks a transfer with an error.
- IDLE: dValid=0 & dAck=1 → SPURIOUS_ACK. dValid=1 → capture `cap`=data, b=1, dirty=0; in that same cycle evaluate the ACTIVE ack rules with b=1.
- ACTIVE (b = current beat):
  - dValid=0 → NO_ACK, go to IDLE.
  - data≠`cap` → DATA_UNSTABLE, dirty=1, stay in the current state.
  - dAck=1 & b<`MIN_VALID` → ACK_EARLY, go to RECOVER.
  - dAck=1 & b≥`MIN_VALID` → ACKED.
  - dAck=0 & b=`MAX_VALID`+1 → LEN_LONG, go to RECOVER; otherwise b++.
- ACKED: dValid=1 → NO_DROP, go to RECOVER. dValid=0 → IDLE, and xfer_cnt++ if !dirty.
- RECOVER: no new errors. dValid=0 → IDLE.
- Multiple errors on one edge: all matching bits are set; `err_code` takes the lowest bit index; `err_cnt` increments by 1.
- `err_code` is written only while it is 0.
- `err_clr` with a simultaneous new error: the new error's bits and code survive.
- Back-to-back transfers: a new transfer requires dValid low for ≥1 cycle (a rise).

## Timing
- All detection is registered. An error sampled at edge N appears on `err_flags`/`err_pulse`/`err_code` after edge N; `err_pulse` deasserts after edge N+1 unless there is another error.
- `xfer_cnt` updates after the edge that samples dValid=0 in ACKED.
- Reset (asynchronous, mid-transfer included) forces: state IDLE, b=0, `cap`=0, all outputs 0.
- Counters saturate at 2^`CNT_W`−1; they do not wrap.

## Configuration
- `BUS_CHK_ERRCNT_EN` defined: `err_cnt` is a saturating counter of error edges, cleared only by reset.
- Not defined: the `err_cnt` register is removed and the port is tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- Defaults. dValid high 3 beats, data=0xA5 stable, dAck on beat 3, dValid low next cycle → `xfer_cnt`=1, `err_flags`=0, `err_pulse` never high.
- dAck on beat 1 of dValid rise → ACK_EARLY: `err_flags`=6'b000010, `err_code`=2, state RECOVER until dValid=0, `xfer_cnt` unchanged.
- dValid high 5 beats, no dAck → LEN_LONG on beat 5: `err_code`=3, `err_pulse` high exactly one cycle.
- Data 0x3C→0x3D on beat 2, legal ack on beat 2, and dValid still high after ack → DATA_UNSTABLE then NO_DROP: `err_flags`=6'b110000, `err_code`=6, `xfer_cnt`=0. Then assert `err_clr` → flags 0, code 0.
- `MIN_VALID`=1, `MAX_VALID`=8, `DATA_W`=32: ack on beat 1 is legal (`xfer_cnt`=1); dAck with dValid low → SPURIOUS_ACK, `err_code`=1. Assert `reset` low mid-transfer → all outputs 0 immediately, without waiting for a clock edge.
- With `BUS_CHK_ERRCNT_EN`: 3 bad transfers → `err_cnt`=3. Without the macro: same stimulus → `err_cnt`=0.

Source files
------------

// File: rtl/bus_protocol_checker.sv
// Passive run-time checker for the dValid/dAck/data bus: per-transfer FSM plus sticky error flags.
// Optional BUS_CHK_ERRCNT_EN keeps a saturating error-edge counter on err_cnt; otherwise err_cnt is tied to 0.
module bus_protocol_checker #(
  parameter int DATA_W    = 8,
  parameter int MIN_VALID = 2,
  parameter int MAX_VALID = 4,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dValid,
  input  logic              dAck,
  input  logic [DATA_W-1:0] data,
  input  logic              err_clr,
  output logic              busy,
  output logic              err_pulse,
  output logic [5:0]        err_flags,
  output logic [2:0]        err_code,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam int BW = $clog2(MAX_VALID + 2);
  localparam logic [BW-1:0] MIN_B     = BW'(MIN_VALID);
  localparam logic [BW-1:0] LEN_LIMIT = BW'(MAX_VALID + 1);

  localparam int E_SPURIOUS_ACK  = 0;
  localparam int E_ACK_EARLY     = 1;
  localparam int E_LEN_LONG      = 2;
  localparam int E_NO_ACK        = 3;
  localparam int E_NO_DROP       = 4;
  localparam int E_DATA_UNSTABLE = 5;

  typedef enum logic [1:0] {IDLE, ACTIVE, ACKED, RECOVER} state_t;

  state_t              state_reg, state_next;
  logic [BW-1:0]       beat_reg, beat_next, beat_eval;
  logic [DATA_W-1:0]   cap_reg, cap_next;
  logic                dirty_reg, dirty_next;
  logic                take_beat;
  logic [5:0]          new_err;
  logic                xfer_done;
  logic [5:0]          flags_reg, flags_next;
  logic [2:0]          code_reg, code_next, code_new;
  logic                pulse_reg;
  logic [CNT_W-1:0]    xfer_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    cap_next   = cap_reg;
    dirty_next = dirty_reg;
    new_err    = '0;
    xfer_done  = 1'b0;
    take_beat  = 1'b0;
    // The first beat is judged in IDLE itself, as beat number 1.
    beat_eval  = (state_reg == IDLE) ? BW'(1) : beat_reg;
    unique case (state_reg)
      IDLE: begin
        if (dValid) begin
          cap_next   = data;
          dirty_next = 1'b0;
          take_beat  = 1'b1;
        end else if (dAck) begin
          new_err[E_SPURIOUS_ACK] = 1'b1;
        end
      end
      ACTIVE: begin
        if (!dValid) begin
          new_err[E_NO_ACK] = 1'b1;
          state_next = IDLE;
          beat_next  = '0;
        end else begin
          if (data != cap_reg) begin
            new_err[E_DATA_UNSTABLE] = 1'b1;
            dirty_next = 1'b1;
          end
          take_beat = 1'b1;
        end
      end
      ACKED: begin
        if (dValid) begin
          new_err[E_NO_DROP] = 1'b1;
          state_next = RECOVER;
        end else begin
          xfer_done  = !dirty_reg;
          state_next = IDLE;
          beat_next  = '0;
        end
      end
      RECOVER: begin
        if (!dValid) begin
          state_next = IDLE;
          beat_next  = '0;
        end
      end
    endcase

    // Ack/length rules run concurrently with the data-stability check.
    if (take_beat) begin
      if (dAck) begin
        if (beat_eval < MIN_B) begin
          new_err[E_ACK_EARLY] = 1'b1;
          state_next = RECOVER;
        end else begin
          state_next = ACKED;
        end
      end else if (beat_eval == LEN_LIMIT) begin
        new_err[E_LEN_LONG] = 1'b1;
        state_next = RECOVER;
      end else begin
        state_next = ACTIVE;
        beat_next  = beat_eval + BW'(1);
      end
    end
  end

  always_comb begin
    busy = (state_reg != IDLE);
  end

  always_comb begin
    code_new = '0;
    for (int i = 5; i >= 0; i--) begin
      if (new_err[i]) code_new = 3'(i + 1);
    end
    flags_next = (err_clr ? 6'd0 : flags_reg) | new_err;
    // A clear coinciding with a new error leaves that error's code in place.
    if (err_clr || code_reg == 3'd0) code_next = code_new;
    else                             code_next = code_reg;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_reg  <= '0;
      cap_reg   <= '0;
      dirty_reg <= 1'b0;
      flags_reg <= '0;
      code_reg  <= '0;
      pulse_reg <= 1'b0;
      xfer_reg  <= '0;
    end else begin
      beat_reg  <= beat_next;
      cap_reg   <= cap_next;
      dirty_reg <= dirty_next;
      flags_reg <= flags_next;
      code_reg  <= code_next;
      pulse_reg <= |new_err;
      if (xfer_done && (xfer_reg != {CNT_W{1'b1}})) xfer_reg <= xfer_reg + CNT_W'(1);
    end
  end

  assign err_pulse = pulse_reg;
  assign err_flags = flags_reg;
  assign err_code  = code_reg;
  assign xfer_cnt  = xfer_reg;

`ifdef BUS_CHK_ERRCNT_EN
  logic [CNT_W-1:0] errcnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) errcnt_reg <= '0;
    else if ((|new_err) && (errcnt_reg != {CNT_W{1'b1}})) errcnt_reg <= errcnt_reg + CNT_W'(1);
  end

  assign err_cnt = errcnt_reg;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_bus_protocol_checker.sv
// Scoreboard bench for bus_protocol_checker: a default instance and a MIN=1/MAX=8/32-bit instance.
module tb_bus_protocol_checker;

`ifdef BUS_CHK_ERRCNT_EN
  localparam int ECNT_EN = 1;
`else
  localparam int ECNT_EN = 0;
`endif

  localparam int F_BUSY  = 0;
  localparam int F_PULSE = 1;
  localparam int F_FLAGS = 2;
  localparam int F_CODE  = 3;
  localparam int F_XFER  = 4;
  localparam int F_ECNT  = 5;

  typedef struct {
    string tag;
    int    unit;
    int    field;
    int    val;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cycle = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, dvalid, dack, err_clr;
  logic [7:0]  data;
  logic        busy, err_pulse;
  logic [5:0]  err_flags;
  logic [2:0]  err_code;
  logic [15:0] xfer_cnt, err_cnt;

  logic        reset_w, dvalid_w, dack_w, err_clr_w;
  logic [31:0] data_w;
  logic        busy_w, err_pulse_w;
  logic [5:0]  err_flags_w;
  logic [2:0]  err_code_w;
  logic [15:0] xfer_cnt_w, err_cnt_w;

  bus_protocol_checker dut (
    .clk(clk), .reset(reset), .dValid(dvalid), .dAck(dack), .data(data), .err_clr(err_clr),
    .busy(busy), .err_pulse(err_pulse), .err_flags(err_flags), .err_code(err_code),
    .xfer_cnt(xfer_cnt), .err_cnt(err_cnt)
  );

  bus_protocol_checker #(.DATA_W(32), .MIN_VALID(1), .MAX_VALID(8), .CNT_W(16)) dut_w (
    .clk(clk), .reset(reset_w), .dValid(dvalid_w), .dAck(dack_w), .data(data_w), .err_clr(err_clr_w),
    .busy(busy_w), .err_pulse(err_pulse_w), .err_flags(err_flags_w), .err_code(err_code_w),
    .xfer_cnt(xfer_cnt_w), .err_cnt(err_cnt_w)
  );

  task automatic check_val(input string tag, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic int read_field(input int unit, input int field);
    int v;
    v = 0;
    if (unit == 0) begin
      case (field)
        F_BUSY:  v = int'(busy);
        F_PULSE: v = int'(err_pulse);
        F_FLAGS: v = int'(err_flags);
        F_CODE:  v = int'(err_code);
        F_XFER:  v = int'(xfer_cnt);
        default: v = int'(err_cnt);
      endcase
    end else begin
      case (field)
        F_BUSY:  v = int'(busy_w);
        F_PULSE: v = int'(err_pulse_w);
        F_FLAGS: v = int'(err_flags_w);
        F_CODE:  v = int'(err_code_w);
        F_XFER:  v = int'(xfer_cnt_w);
        default: v = int'(err_cnt_w);
      endcase
    end
    return v;
  endfunction

  task automatic push_exp(input string tag, input int unit, input int field, input int val);
    exp_t e;
    e.tag = tag; e.unit = unit; e.field = field; e.val = val;
    sb.push_back(e);
  endtask

  task automatic exp_st(input int unit, input string tag, input int b, input int p,
                        input int f, input int c, input int x);
    push_exp({tag, ".busy"},  unit, F_BUSY,  b);
    push_exp({tag, ".pulse"}, unit, F_PULSE, p);
    push_exp({tag, ".flags"}, unit, F_FLAGS, f);
    push_exp({tag, ".code"},  unit, F_CODE,  c);
    push_exp({tag, ".xfer"},  unit, F_XFER,  x);
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check_val(e.tag, read_field(e.unit, e.field), e.val);
    end
  endtask

  task automatic tick(input logic dv, input logic da, input logic [7:0] d, input logic clr);
    dvalid = dv; dack = da; data = d; err_clr = clr;
    @(posedge clk);
    #1;
    cycle++;
    $display("cyc %0d A: v=%0b a=%0b d=%h clr=%0b -> busy=%0b pulse=%0b flags=%b code=%0d xfer=%0d ecnt=%0d",
             cycle, dv, da, d, clr, busy, err_pulse, err_flags, err_code, xfer_cnt, err_cnt);
    drain();
  endtask

  task automatic tick_w(input logic dv, input logic da, input logic [31:0] d, input logic clr);
    dvalid_w = dv; dack_w = da; data_w = d; err_clr_w = clr;
    @(posedge clk);
    #1;
    cycle++;
    $display("cyc %0d B: v=%0b a=%0b d=%h clr=%0b -> busy=%0b pulse=%0b flags=%b code=%0d xfer=%0d ecnt=%0d",
             cycle, dv, da, d, clr, busy_w, err_pulse_w, err_flags_w, err_code_w, xfer_cnt_w, err_cnt_w);
    drain();
  endtask

  initial begin
    reset = 1'b0; dvalid = 1'b0; dack = 1'b0; data = '0; err_clr = 1'b0;
    reset_w = 1'b0; dvalid_w = 1'b0; dack_w = 1'b0; data_w = '0; err_clr_w = 1'b0;
    #1;
    exp_st(0, "rst", 0, 0, 0, 0, 0);
    push_exp("rst.ecnt", 0, F_ECNT, 0);
    exp_st(1, "rst_w", 0, 0, 0, 0, 0);
    tick(1'b1, 1'b1, 8'hFF, 1'b0);
    tick(1'b0, 1'b0, 8'h00, 1'b0);
    reset = 1'b1;
    reset_w = 1'b1;

    // Clean 3-beat transfer, ack on beat 3
    exp_st(0, "t1b1", 1, 0, 0, 0, 0); tick(1, 0, 8'hA5, 0);
    exp_st(0, "t1b2", 1, 0, 0, 0, 0); tick(1, 0, 8'hA5, 0);
    exp_st(0, "t1b3", 1, 0, 0, 0, 0); tick(1, 1, 8'hA5, 0);
    exp_st(0, "t1end", 0, 0, 0, 0, 1); tick(0, 0, 8'hA5, 0);

    // Ack on the rising beat -> ACK_EARLY, then RECOVER until dValid drops
    exp_st(0, "t2b1", 1, 1, 6'h02, 2, 1); tick(1, 1, 8'h11, 0);
    exp_st(0, "t2rec", 1, 0, 6'h02, 2, 1); tick(1, 0, 8'h11, 0);
    exp_st(0, "t2rec2", 1, 0, 6'h02, 2, 1); tick(1, 1, 8'h22, 0);
    exp_st(0, "t2end", 0, 0, 6'h02, 2, 1); tick(0, 0, 8'h00, 0);
    exp_st(0, "t2clr", 0, 0, 0, 0, 1); tick(0, 0, 8'h00, 1);

    // Five beats without ack -> LEN_LONG on beat 5, pulse one cycle only
    for (int i = 1; i <= 4; i++) begin
      exp_st(0, $sformatf("t3b%0d", i), 1, 0, 0, 0, 1); tick(1, 0, 8'h5A, 0);
    end
    exp_st(0, "t3b5", 1, 1, 6'h04, 3, 1); tick(1, 0, 8'h5A, 0);
    exp_st(0, "t3end", 0, 0, 6'h04, 3, 1); tick(0, 0, 8'h00, 0);
    exp_st(0, "t3clr", 0, 0, 0, 0, 1); tick(0, 0, 8'h00, 1);

    // Data change with legal ack, then dValid held -> DATA_UNSTABLE then NO_DROP
    exp_st(0, "t4b1", 1, 0, 0, 0, 1); tick(1, 0, 8'h3C, 0);
    exp_st(0, "t4b2", 1, 1, 6'h20, 6, 1); tick(1, 1, 8'h3D, 0);
    exp_st(0, "t4b3", 1, 1, 6'h30, 6, 1); tick(1, 0, 8'h3D, 0);
    exp_st(0, "t4end", 0, 0, 6'h30, 6, 1); tick(0, 0, 8'h00, 0);
    exp_st(0, "t4clr", 0, 0, 0, 0, 1); tick(0, 0, 8'h00, 1);

    // Legal acks at exactly MIN_VALID and exactly MAX_VALID beats
    exp_st(0, "t5b1", 1, 0, 0, 0, 1); tick(1, 0, 8'h77, 0);
    exp_st(0, "t5b2", 1, 0, 0, 0, 1); tick(1, 1, 8'h77, 0);
    exp_st(0, "t5end", 0, 0, 0, 0, 2); tick(0, 0, 8'h00, 0);
    for (int i = 1; i <= 3; i++) begin
      exp_st(0, $sformatf("t5m%0d", i), 1, 0, 0, 0, 2); tick(1, 0, 8'h66, 0);
    end
    exp_st(0, "t5m4", 1, 0, 0, 0, 2); tick(1, 1, 8'h66, 0);
    exp_st(0, "t5mend", 0, 0, 0, 0, 3); tick(0, 0, 8'h00, 0);

    // Dirty transfer completes normally but is not counted
    exp_st(0, "t6b1", 1, 0, 0, 0, 3); tick(1, 0, 8'h3C, 0);
    exp_st(0, "t6b2", 1, 1, 6'h20, 6, 3); tick(1, 1, 8'h3D, 0);
    exp_st(0, "t6end", 0, 0, 6'h20, 6, 3); tick(0, 0, 8'h00, 0);

    // Clear coinciding with SPURIOUS_ACK keeps the new error; later code is not overwritten
    exp_st(0, "t7spur", 0, 1, 6'h01, 1, 3); tick(0, 1, 8'h00, 1);
    exp_st(0, "t7b1", 1, 0, 6'h01, 1, 3); tick(1, 0, 8'h44, 0);
    exp_st(0, "t7noack", 0, 1, 6'h09, 1, 3); tick(0, 0, 8'h00, 0);
    exp_st(0, "t7clr", 0, 0, 0, 0, 3); tick(0, 0, 8'h00, 1);

    // Asynchronous reset mid-transfer on the default instance
    exp_st(0, "t8b1", 1, 0, 0, 0, 3); tick(1, 0, 8'h12, 0);
    reset = 1'b0;
    #1;
    exp_st(0, "t8arst", 0, 0, 0, 0, 0);
    push_exp("t8arst.ecnt", 0, F_ECNT, 0);
    drain();
    dvalid = 1'b0;
    #1;
    reset = 1'b1;

    // Three bad transfers after reset; the third has two errors on one edge
    exp_st(0, "t9early", 1, 1, 6'h02, 2, 0); tick(1, 1, 8'h00, 0);
    exp_st(0, "t9idle", 0, 0, 6'h02, 2, 0); tick(0, 0, 8'h00, 0);
    exp_st(0, "t9b1", 1, 0, 6'h02, 2, 0); tick(1, 0, 8'h00, 0);
    exp_st(0, "t9noack", 0, 1, 6'h0A, 2, 0); tick(0, 0, 8'h00, 0);
    for (int i = 1; i <= 4; i++) begin
      exp_st(0, $sformatf("t9l%0d", i), 1, 0, 6'h0A, 2, 0); tick(1, 0, 8'h55, 0);
    end
    exp_st(0, "t9l5", 1, 1, 6'h2E, 2, 0);
    push_exp("t9l5.ecnt", 0, F_ECNT, 3 * ECNT_EN);
    tick(1, 0, 8'hAA, 0);
    exp_st(0, "t9end", 0, 0, 6'h2E, 2, 0); tick(0, 0, 8'h00, 0);

    // Wide instance: ack on beat 1 is legal when MIN_VALID=1
    exp_st(1, "w1b1", 1, 0, 0, 0, 0); tick_w(1, 1, 32'hDEADBEEF, 0);
    exp_st(1, "w1end", 0, 0, 0, 0, 1); tick_w(0, 0, 32'h0, 0);
    exp_st(1, "w2spur", 0, 1, 6'h01, 1, 1);
    push_exp("w2spur.ecnt", 1, F_ECNT, ECNT_EN);
    tick_w(0, 1, 32'h0, 0);
    exp_st(1, "w2clr", 0, 0, 0, 0, 1); tick_w(0, 0, 32'h0, 1);

    // Eight beats with ack on beat 8 sits exactly at MAX_VALID
    for (int i = 1; i <= 7; i++) begin
      exp_st(1, $sformatf("w3b%0d", i), 1, 0, 0, 0, 1); tick_w(1, 0, 32'h12345678, 0);
    end
    exp_st(1, "w3b8", 1, 0, 0, 0, 1); tick_w(1, 1, 32'h12345678, 0);
    exp_st(1, "w3end", 0, 0, 0, 0, 2); tick_w(0, 0, 32'h0, 0);

    exp_st(1, "w4b1", 1, 0, 0, 0, 2); tick_w(1, 0, 32'hCAFEF00D, 0);
    exp_st(1, "w4b2", 1, 0, 0, 0, 2); tick_w(1, 0, 32'hCAFEF00D, 0);
    reset_w = 1'b0;
    #1;
    exp_st(1, "w4arst", 0, 0, 0, 0, 0);
    push_exp("w4arst.ecnt", 1, F_ECNT, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
